connect4_board_ctrl: RTL and testbench

- Game-state engine that owns the 6x7 Connect-4 board.
- Accepts column drop requests from the input/debounce logic and applies gravity.
- Places the current player's piece, checks for four-in-a-row, then alternates turns.
- Drives the board array consumed by the VGA grid renderer as a 2-bit per-cell code: 00 empty, 01 red, 10 yellow. Row 0 is the top row, row 5 the bottom.

---
 rtl/connect4_board_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_connect4_board_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/connect4_board_ctrl.sv
// Connect-4 game-state engine: owns the 6x7 board, applies gravity to column drops,
// checks four-in-a-row around each new piece and alternates turns.
module connect4_board_ctrl #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              new_game,
    input  logic                              drop_valid,
    input  logic [2:0]                        drop_col,
    output logic                              drop_ready,
    output logic [0:ROWS-1][0:COLS-1][1:0]    tablero,
    output logic [1:0]                        current_player,
    output logic                              move_done,
    output logic                              move_invalid,
    output logic [1:0]                        winner,
    output logic                              board_full,
    output logic                              busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int MW = $clog2(ROWS * COLS + 1);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] RED   = 2'b01;
    localparam logic [1:0] YEL   = 2'b10;

    typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        PLACE,
        CHECK,
        OVER
    } state_t;

    state_t state, state_next;

    logic [2:0]    col;
    logic [RW-1:0] scan_row;
    logic [RW-1:0] place_row;
    logic [1:0]    dir;
    logic          win_acc;
    logic [MW-1:0] move_cnt;

    logic accept;
    logic reject;
    logic place_found;
    logic scan_dec;
    logic last_check;
    logic check_hit;
    logic win_now;
    logic full_now;
    int   dr;
    int   dc;

    // Length of the run of 'who' through (pr,pc) along +/-(dr,dc), each side capped at WIN_LEN-1.
    function automatic int line_len(input board_t board, input int pr, input int pc,
                                    input int sr, input int sc, input logic [1:0] who);
        int   n;
        int   r;
        int   c;
        logic run;
        n = 1;
        for (int side = 0; side < 2; side++) begin
            run = 1'b1;
            for (int k = 1; k < WIN_LEN; k++) begin
                r = (side == 0) ? pr + k * sr : pr - k * sr;
                c = (side == 0) ? pc + k * sc : pc - k * sc;
                if (run && r >= 0 && r < ROWS && c >= 0 && c < COLS &&
                    board[r[RW-1:0]][c[2:0]] == who) begin
                    n = n + 1;
                end else begin
                    run = 1'b0;
                end
            end
        end
        return n;
    endfunction

    always_comb begin
        dr = 0;
        dc = 1;
        case (dir)
            2'd0:    begin dr = 0;  dc = 1; end
            2'd1:    begin dr = 1;  dc = 0; end
            2'd2:    begin dr = 1;  dc = 1; end
            default: begin dr = -1; dc = 1; end
        endcase
        check_hit = (line_len(tablero, int'(place_row), int'(col), dr, dc, current_player) >= WIN_LEN);
        win_now   = win_acc | check_hit;
        full_now  = (move_cnt == MW'(ROWS * COLS));
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        reject      = 1'b0;
        place_found = 1'b0;
        scan_dec    = 1'b0;
        last_check  = 1'b0;
        case (state)
            IDLE: begin
                if (drop_valid) begin
                    if (int'(drop_col) >= COLS) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = SCAN;
                    end
                end
            end
            SCAN: begin
                // Scan bottom-up for the first empty cell; reaching row 0 occupied means column full.
                if (tablero[scan_row][col] == EMPTY) begin
                    place_found = 1'b1;
                    state_next  = PLACE;
                end else if (scan_row == '0) begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end else begin
                    scan_dec = 1'b1;
                end
            end
            PLACE: begin
                state_next = CHECK;
            end
            CHECK: begin
                if (dir == 2'd3) begin
                    last_check = 1'b1;
                    state_next = (win_now || full_now) ? OVER : IDLE;
                end
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            tablero        <= '0;
            current_player <= RED;
            winner         <= EMPTY;
            board_full     <= 1'b0;
            move_done      <= 1'b0;
            move_invalid   <= 1'b0;
            move_cnt       <= '0;
            win_acc        <= 1'b0;
            col            <= '0;
            scan_row       <= '0;
            place_row      <= '0;
            dir            <= '0;
        end else begin
            move_done    <= last_check;
            move_invalid <= reject;
            if (accept) begin
                col      <= drop_col;
                scan_row <= RW'(ROWS - 1);
            end
            if (scan_dec) begin
                scan_row <= scan_row - RW'(1);
            end
            if (place_found) begin
                place_row <= scan_row;
            end
            if (state == PLACE) begin
                tablero[place_row][col] <= current_player;
                move_cnt                <= move_cnt + MW'(1);
                dir                     <= 2'd0;
                win_acc                 <= 1'b0;
            end
            if (state == CHECK) begin
                dir <= dir + 2'd1;
                if (check_hit) begin
                    win_acc <= 1'b1;
                end
            end
            // Outcome is resolved on the last direction, including a hit found in that same cycle.
            if (last_check) begin
                if (win_now) begin
                    winner <= current_player;
                end else if (full_now) begin
                    board_full <= 1'b1;
                end else begin
                    current_player <= (current_player == RED) ? YEL : RED;
                end
            end
        end
    end

    assign drop_ready = (state == IDLE);
    assign busy       = (state == SCAN) || (state == PLACE) || (state == CHECK);

endmodule

// File: tb/tb_connect4_board_ctrl.sv
// Bench for connect4_board_ctrl: scripted games plus random games against a board-level reference model.
module tb_connect4_board_ctrl;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int WIN  = 4;
    localparam int WIN_WINDOW = 15;

    typedef logic [0:ROWS-1][0:COLS-1][1:0] board_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_game;
    logic       drop_valid;
    logic [2:0] drop_col;
    logic       drop_ready;
    board_t     tablero;
    logic [1:0] current_player;
    logic       move_done;
    logic       move_invalid;
    logic [1:0] winner;
    logic       board_full;
    logic       busy;

    int errors = 0;
    int checks = 0;

    int mb [ROWS][COLS];
    int m_player;
    int m_winner;
    int m_full;
    int m_over;
    int m_moves;

    connect4_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN)) dut (
        .clk            (clk),
        .rst            (rst),
        .new_game       (new_game),
        .drop_valid     (drop_valid),
        .drop_col       (drop_col),
        .drop_ready     (drop_ready),
        .tablero        (tablero),
        .current_player (current_player),
        .move_done      (move_done),
        .move_invalid   (move_invalid),
        .winner         (winner),
        .board_full     (board_full),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        m_player = 1;
        m_winner = 0;
        m_full   = 0;
        m_over   = 0;
        m_moves  = 0;
    endtask

    function automatic board_t model_board();
        board_t b;
        b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[r[2:0]][c[2:0]] = 2'(mb[r][c]);
        return b;
    endfunction

    // Whole-board search for any line of WIN equal pieces.
    function automatic int model_winner();
        int sr [4] = '{0, 1, 1, -1};
        int sc [4] = '{1, 0, 1, 1};
        int p;
        int rr;
        int cc;
        int ok;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                for (int d = 0; d < 4; d++) begin
                    p  = mb[r][c];
                    ok = (p != 0);
                    for (int k = 1; k < WIN; k++) begin
                        rr = r + k * sr[d];
                        cc = c + k * sc[d];
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 0;
                        else if (mb[rr][cc] != p) ok = 0;
                    end
                    if (ok != 0) return p;
                end
        return 0;
    endfunction

    task automatic check_state(input string tag);
        check_val({tag, "/board"},  128'(tablero),        128'(model_board()));
        check_val({tag, "/player"}, 128'(current_player), 128'(m_player));
        check_val({tag, "/winner"}, 128'(winner),         128'(m_winner));
        check_val({tag, "/full"},   128'(board_full),     128'(m_full));
        check_val({tag, "/ready"},  128'(drop_ready),     128'(m_over == 0));
        check_val({tag, "/busy"},   128'(busy),           128'(0));
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        clk_step();
        new_game = 1'b0;
        model_reset();
    endtask

    // kind: 0 legal, 1 column full, 2 bad column, 3 ignored (game over)
    task automatic do_drop(input int c, input string tag);
        int kind;
        int k;
        int row;
        int exp_done;
        int exp_inv;
        int exp_cell;
        int done_at;
        int inv_at;
        int done_n;
        int inv_n;
        int both;
        int cell_at;
        int w;
        k = 0;
        row = 0;
        done_at = 0;
        inv_at = 0;
        done_n = 0;
        inv_n = 0;
        both = 0;
        cell_at = 0;
        if (m_over != 0) begin
            kind = 3;
        end else if (c >= COLS) begin
            kind = 2;
        end else begin
            for (int r = 0; r < ROWS; r++)
                if (mb[r][c] != 0) k++;
            kind = (k == ROWS) ? 1 : 0;
            row = ROWS - 1 - k;
        end
        exp_done = (kind == 0) ? k + 7 : 0;
        exp_inv  = (kind == 1) ? 7 : (kind == 2) ? 1 : 0;
        exp_cell = (kind == 0) ? k + 3 : 0;
        check_val({tag, "/ready_before"}, 128'(drop_ready), 128'(m_over == 0));

        drop_col   = c[2:0];
        drop_valid = 1'b1;
        clk_step();
        drop_valid = 1'b0;
        for (int n = 1; n <= WIN_WINDOW; n++) begin
            if (move_done) begin
                done_n++;
                if (done_at == 0) done_at = n;
            end
            if (move_invalid) begin
                inv_n++;
                if (inv_at == 0) inv_at = n;
            end
            if (move_done && move_invalid) both++;
            if (kind == 0 && cell_at == 0 && tablero[row[2:0]][c[2:0]] != 2'b00) cell_at = n;
            if (n < WIN_WINDOW) clk_step();
        end

        check_val({tag, "/done_cycle"},   128'(done_at), 128'(exp_done));
        check_val({tag, "/done_pulses"},  128'(done_n),  128'(kind == 0));
        check_val({tag, "/inv_cycle"},    128'(inv_at),  128'(exp_inv));
        check_val({tag, "/inv_pulses"},   128'(inv_n),   128'(kind == 1 || kind == 2));
        check_val({tag, "/pulse_overlap"}, 128'(both),   128'(0));
        if (kind == 0) begin
            check_val({tag, "/cell_visible"}, 128'(cell_at), 128'(exp_cell));
            mb[row][c] = m_player;
            m_moves++;
            w = model_winner();
            if (w != 0) begin
                m_winner = w;
                m_over   = 1;
            end else if (m_moves == ROWS * COLS) begin
                m_full = 1;
                m_over = 1;
            end else begin
                m_player = 3 - m_player;
            end
        end
        check_state(tag);
    endtask

    initial begin
        int seq_h [7]  = '{0, 0, 1, 1, 2, 2, 3};
        int seq_d [11] = '{0, 1, 1, 2, 2, 3, 2, 3, 3, 6, 3};
        int seq_f [12] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0};

        rst        = 1'b1;
        new_game   = 1'b0;
        drop_valid = 1'b0;
        drop_col   = 3'd0;
        model_reset();
        repeat (3) clk_step();
        rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 3; i++) begin
            clk_step();
            check_val("idle/move_done",    128'(move_done),    128'(0));
            check_val("idle/move_invalid", 128'(move_invalid), 128'(0));
        end
        check_state("reset");

        // First drop and stacked second drop
        do_drop(3, "first");
        check_val("first/cell53", 128'(tablero[5][3]), 128'(2'b01));
        do_drop(3, "second");
        check_val("second/cell43", 128'(tablero[4][3]), 128'(2'b10));

        // Column-full and bad-column rejections
        do_new_game();
        check_state("ng1");
        for (int i = 0; i < 6; i++) do_drop(0, "fill_col0");
        do_drop(0, "col_full");
        do_drop(7, "bad_col");

        // Horizontal win, then a drop while game over
        do_new_game();
        foreach (seq_h[i]) do_drop(seq_h[i], "horiz");
        check_val("horiz/winner", 128'(winner), 128'(2'b01));
        check_val("horiz/ready",  128'(drop_ready), 128'(0));
        do_drop(4, "horiz_over");

        // Diagonal win
        do_new_game();
        foreach (seq_d[i]) do_drop(seq_d[i], "diag");
        check_val("diag/winner", 128'(winner), 128'(2'b01));
        check_val("diag/cells",
                  128'({tablero[5][0], tablero[4][1], tablero[3][2], tablero[2][3]}),
                  128'(8'b01_01_01_01));

        // new_game while CHECK is running
        do_new_game();
        drop_col   = 3'd2;
        drop_valid = 1'b1;
        clk_step();
        drop_valid = 1'b0;
        clk_step();
        clk_step();
        clk_step();
        check_val("ng_check/busy_before", 128'(busy), 128'(1));
        check_val("ng_check/cell_before", 128'(tablero[5][2]), 128'(2'b01));
        new_game = 1'b1;
        clk_step();
        new_game = 1'b0;
        model_reset();
        check_val("ng_check/move_done", 128'(move_done), 128'(0));
        check_state("ng_check");
        for (int i = 0; i < 4; i++) begin
            clk_step();
            check_val("ng_check/no_done_after", 128'(move_done), 128'(0));
        end

        // 42-move draw
        do_new_game();
        for (int p = 0; p < 3; p++)
            foreach (seq_f[i]) do_drop(seq_f[i] + 2 * p, "draw");
        for (int i = 0; i < 6; i++) do_drop(6, "draw");
        check_val("draw/full",   128'(board_full), 128'(1));
        check_val("draw/winner", 128'(winner),     128'(0));

        // Random games
        for (int g = 0; g < 12; g++) begin
            do_new_game();
            for (int m = 0; m < 60 && m_over == 0; m++)
                do_drop(int'($urandom_range(0, 7)), "rand");
            do_drop(int'($urandom_range(0, 7)), "rand_end");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
